// File: rtl/nasti_read_narrower.sv
`default_nettype none
// ============================================================================
//  Module   : nasti_read_narrower
//  Purpose  : Read-channel half of a NASTI (AXI4) data-width down-converter.
//             A wide master read burst is turned into one or more narrow slave
//             bursts, and the narrow beats are reassembled into master-width
//             beats. One master transaction is in flight at a time.
//  Ports    : clk, rstn          - clock, asynchronous active-low reset
//             master_ar_*        - wide read request (ready only when idle)
//             master_r_*         - wide read response (one buffered beat)
//             slave_ar_*         - narrow read request(s)
//             slave_r_*          - narrow read response (last/id unused)
//  Revision : 1.0 - initial release
// ============================================================================
module nasti_read_narrower #(
  parameter int ID_WIDTH          = 1,
  parameter int ADDR_WIDTH        = 8,
  parameter int MASTER_DATA_WIDTH = 64,
  parameter int SLAVE_DATA_WIDTH  = 64,
  parameter int USER_WIDTH        = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [ID_WIDTH-1:0]          master_ar_id,
  input  logic [ADDR_WIDTH-1:0]        master_ar_addr,
  input  logic [7:0]                   master_ar_len,
  input  logic [2:0]                   master_ar_size,
  input  logic [1:0]                   master_ar_burst,
  input  logic                         master_ar_lock,
  input  logic [3:0]                   master_ar_cache,
  input  logic [2:0]                   master_ar_prot,
  input  logic [3:0]                   master_ar_qos,
  input  logic [3:0]                   master_ar_region,
  input  logic [USER_WIDTH-1:0]        master_ar_user,
  input  logic                         master_ar_valid,
  output logic                         master_ar_ready,
  output logic [ID_WIDTH-1:0]          master_r_id,
  output logic [MASTER_DATA_WIDTH-1:0] master_r_data,
  output logic [1:0]                   master_r_resp,
  output logic                         master_r_last,
  output logic [USER_WIDTH-1:0]        master_r_user,
  output logic                         master_r_valid,
  input  logic                         master_r_ready,
  output logic [ID_WIDTH-1:0]          slave_ar_id,
  output logic [ADDR_WIDTH-1:0]        slave_ar_addr,
  output logic [7:0]                   slave_ar_len,
  output logic [2:0]                   slave_ar_size,
  output logic [1:0]                   slave_ar_burst,
  output logic                         slave_ar_lock,
  output logic [3:0]                   slave_ar_cache,
  output logic [2:0]                   slave_ar_prot,
  output logic [3:0]                   slave_ar_qos,
  output logic [3:0]                   slave_ar_region,
  output logic [USER_WIDTH-1:0]        slave_ar_user,
  output logic                         slave_ar_valid,
  input  logic                         slave_ar_ready,
  input  logic [ID_WIDTH-1:0]          slave_r_id,
  input  logic [SLAVE_DATA_WIDTH-1:0]  slave_r_data,
  input  logic [1:0]                   slave_r_resp,
  input  logic                         slave_r_last,
  input  logic [USER_WIDTH-1:0]        slave_r_user,
  input  logic                         slave_r_valid,
  output logic                         slave_r_ready
);

  localparam int c_sb     = SLAVE_DATA_WIDTH / 8;
  localparam int c_mb     = MASTER_DATA_WIDTH / 8;
  localparam int c_ss     = $clog2(c_sb);
  localparam int c_ms     = $clog2(c_mb);
  localparam int c_ratio  = c_mb / c_sb;
  localparam int c_slot_w = (c_ratio > 1) ? $clog2(c_ratio) : 1;

  typedef enum logic [1:0] {IDLE, SAR, SR, MR} state_t;

  state_t                       r_state, w_state_next;
  logic [ID_WIDTH-1:0]          r_id;
  logic [7:0]                   r_len;
  logic [2:0]                   r_size;
  logic [1:0]                   r_burst;
  logic                         r_lock;
  logic [3:0]                   r_cache, r_qos, r_region;
  logic [2:0]                   r_prot;
  logic [USER_WIDTH-1:0]        r_aruser, r_ruser;
  logic                         r_split;
  logic [ADDR_WIDTH-1:0]        r_addr;
  logic [7:0]                   r_beat, r_sbeat;
  logic [MASTER_DATA_WIDTH-1:0] r_data;
  logic [1:0]                   r_resp;

  logic [ADDR_WIDTH-1:0]        w_size_mask, w_beat_base, w_beat_addr;
  logic [ADDR_WIDTH-1:0]        w_wrap_mask, w_addr_inc, w_addr_next;
  logic [7:0]                   w_split_len;
  logic [c_slot_w-1:0]          w_slot;
  logic [MASTER_DATA_WIDTH-1:0] w_data_merge;
  logic [1:0]                   w_resp_merge;
  logic                         w_split_done, w_last_master;

  // Slave beats carry no trustworthy framing here; beat counting rules.
  logic w_unused;
  assign w_unused = &{1'b0, slave_r_last, slave_r_id, w_beat_addr};

  assign w_size_mask   = (ADDR_WIDTH'(1) << r_size) - ADDR_WIDTH'(1);
  assign w_beat_base   = r_addr & ~w_size_mask;
  assign w_split_len   = 8'((9'd1 << (r_size - 3'(c_ss))) - 9'd1);
  assign w_split_done  = (r_sbeat == w_split_len);
  assign w_last_master = (r_beat == r_len);

  // Byte address of the narrow beat currently being accepted.
  assign w_beat_addr = r_split ? (w_beat_base + (ADDR_WIDTH'(r_sbeat) << c_ss)) : r_addr;

  generate
    if (c_ratio > 1) begin : g_slot_multi
      assign w_slot = w_beat_addr[c_ms-1:c_ss];
    end else begin : g_slot_single
      assign w_slot = '0;
    end
  endgenerate

  always_comb begin
    w_data_merge = r_data;
    for (int k = 0; k < c_ratio; k++) begin
      if (w_slot == c_slot_w'(k)) begin
        w_data_merge[k*SLAVE_DATA_WIDTH +: SLAVE_DATA_WIDTH] = slave_r_data;
      end
    end
  end

  // Worst response of the beats forming one master beat.
  assign w_resp_merge = (slave_r_resp > r_resp) ? slave_r_resp : r_resp;

  // Next master beat address; WRAP stays inside its (len+1)*2^size window.
  assign w_addr_inc  = r_addr + (ADDR_WIDTH'(1) << r_size);
  assign w_wrap_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);

  always_comb begin
    w_addr_next = w_addr_inc;
    case (r_burst)
      2'b00:   w_addr_next = r_addr;
      2'b10:   w_addr_next = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
      default: w_addr_next = w_addr_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (master_ar_valid) w_state_next = SAR;
      SAR:  if (slave_ar_ready) w_state_next = SR;
      SR:   if (slave_r_valid && (!r_split || w_split_done)) w_state_next = MR;
      MR: begin
        if (master_r_ready) begin
          if (w_last_master) w_state_next = IDLE;
          else if (r_split)  w_state_next = SAR;
          else               w_state_next = SR;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_id     <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_lock   <= 1'b0;
      r_cache  <= '0;
      r_prot   <= '0;
      r_qos    <= '0;
      r_region <= '0;
      r_aruser <= '0;
      r_ruser  <= '0;
      r_split  <= 1'b0;
      r_addr   <= '0;
      r_beat   <= '0;
      r_sbeat  <= '0;
      r_data   <= '0;
      r_resp   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (master_ar_valid) begin
            r_id     <= master_ar_id;
            r_len    <= master_ar_len;
            r_size   <= master_ar_size;
            r_burst  <= master_ar_burst;
            r_lock   <= master_ar_lock;
            r_cache  <= master_ar_cache;
            r_prot   <= master_ar_prot;
            r_qos    <= master_ar_qos;
            r_region <= master_ar_region;
            r_aruser <= master_ar_user;
            r_split  <= (master_ar_size > 3'(c_ss));
            r_addr   <= master_ar_addr;
            r_beat   <= '0;
            r_sbeat  <= '0;
          end
        end
        SR: begin
          if (slave_r_valid) begin
            r_data  <= w_data_merge;
            r_resp  <= w_resp_merge;
            r_ruser <= slave_r_user;
            if (r_split) r_sbeat <= w_split_done ? 8'd0 : r_sbeat + 8'd1;
          end
        end
        MR: begin
          if (master_r_ready) begin
            r_data <= '0;
            r_resp <= '0;
            r_addr <= w_addr_next;
            r_beat <= r_beat + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign master_ar_ready = (r_state == IDLE);
  assign slave_ar_valid  = (r_state == SAR);
  assign slave_r_ready   = (r_state == SR);
  assign master_r_valid  = (r_state == MR);

  assign slave_ar_id     = r_id;
  assign slave_ar_addr   = r_split ? w_beat_base : r_addr;
  assign slave_ar_len    = r_split ? w_split_len : r_len;
  assign slave_ar_size   = r_split ? 3'(c_ss) : r_size;
  assign slave_ar_burst  = r_split ? 2'b01 : r_burst;
  assign slave_ar_lock   = r_lock;
  assign slave_ar_cache  = r_cache;
  assign slave_ar_prot   = r_prot;
  assign slave_ar_qos    = r_qos;
  assign slave_ar_region = r_region;
  assign slave_ar_user   = r_aruser;

  assign master_r_id     = r_id;
  assign master_r_data   = r_data;
  assign master_r_resp   = r_resp;
  assign master_r_last   = w_last_master;
  assign master_r_user   = r_ruser;

endmodule
`default_nettype wire

// File: tb/tb_nasti_read_narrower.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nasti_read_narrower
//  Purpose  : Directed self-checking bench for nasti_read_narrower with a
//             64-bit master port and a 32-bit slave port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nasti_read_narrower;

  localparam int MW = 64;
  localparam int SW = 32;

  logic          clk, rstn;
  logic [0:0]    master_ar_id;
  logic [7:0]    master_ar_addr, master_ar_len;
  logic [2:0]    master_ar_size, master_ar_prot;
  logic [1:0]    master_ar_burst;
  logic          master_ar_lock;
  logic [3:0]    master_ar_cache, master_ar_qos, master_ar_region;
  logic [0:0]    master_ar_user;
  logic          master_ar_valid, master_ar_ready;
  logic [0:0]    master_r_id, master_r_user;
  logic [MW-1:0] master_r_data;
  logic [1:0]    master_r_resp;
  logic          master_r_last, master_r_valid, master_r_ready;
  logic [0:0]    slave_ar_id, slave_ar_user;
  logic [7:0]    slave_ar_addr, slave_ar_len;
  logic [2:0]    slave_ar_size, slave_ar_prot;
  logic [1:0]    slave_ar_burst;
  logic          slave_ar_lock;
  logic [3:0]    slave_ar_cache, slave_ar_qos, slave_ar_region;
  logic          slave_ar_valid, slave_ar_ready;
  logic [0:0]    slave_r_id, slave_r_user;
  logic [SW-1:0] slave_r_data;
  logic [1:0]    slave_r_resp;
  logic          slave_r_last, slave_r_valid, slave_r_ready;

  int checks = 0;
  int errors = 0;

  nasti_read_narrower #(
    .ID_WIDTH(1), .ADDR_WIDTH(8), .MASTER_DATA_WIDTH(MW),
    .SLAVE_DATA_WIDTH(SW), .USER_WIDTH(1)
  ) dut (
    .clk(clk), .rstn(rstn),
    .master_ar_id(master_ar_id), .master_ar_addr(master_ar_addr),
    .master_ar_len(master_ar_len), .master_ar_size(master_ar_size),
    .master_ar_burst(master_ar_burst), .master_ar_lock(master_ar_lock),
    .master_ar_cache(master_ar_cache), .master_ar_prot(master_ar_prot),
    .master_ar_qos(master_ar_qos), .master_ar_region(master_ar_region),
    .master_ar_user(master_ar_user), .master_ar_valid(master_ar_valid),
    .master_ar_ready(master_ar_ready),
    .master_r_id(master_r_id), .master_r_data(master_r_data),
    .master_r_resp(master_r_resp), .master_r_last(master_r_last),
    .master_r_user(master_r_user), .master_r_valid(master_r_valid),
    .master_r_ready(master_r_ready),
    .slave_ar_id(slave_ar_id), .slave_ar_addr(slave_ar_addr),
    .slave_ar_len(slave_ar_len), .slave_ar_size(slave_ar_size),
    .slave_ar_burst(slave_ar_burst), .slave_ar_lock(slave_ar_lock),
    .slave_ar_cache(slave_ar_cache), .slave_ar_prot(slave_ar_prot),
    .slave_ar_qos(slave_ar_qos), .slave_ar_region(slave_ar_region),
    .slave_ar_user(slave_ar_user), .slave_ar_valid(slave_ar_valid),
    .slave_ar_ready(slave_ar_ready),
    .slave_r_id(slave_r_id), .slave_r_data(slave_r_data),
    .slave_r_resp(slave_r_resp), .slave_r_last(slave_r_last),
    .slave_r_user(slave_r_user), .slave_r_valid(slave_r_valid),
    .slave_r_ready(slave_r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: each starts and ends at a falling edge.
  task automatic do_ar(input logic [7:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    master_ar_addr = addr; master_ar_len = len;
    master_ar_size = size; master_ar_burst = burst;
    master_ar_valid = 1'b1;
    while (!master_ar_ready && n < 50) begin @(negedge clk); n++; end
    if (!master_ar_ready) begin
      checks++; errors++;
      $display("FAIL ar_handshake_timeout got ready=%b required 1", master_ar_ready);
    end
    @(posedge clk); @(negedge clk);
    master_ar_valid = 1'b0;
  endtask

  task automatic wait_slave_ar(output logic [7:0] addr, output logic [7:0] len,
                               output logic [2:0] size, output logic [1:0] burst);
    int n = 0;
    while (!slave_ar_valid && n < 50) begin @(negedge clk); n++; end
    if (!slave_ar_valid) begin
      checks++; errors++;
      $display("FAIL slave_ar_timeout got valid=%b required 1", slave_ar_valid);
    end
    addr = slave_ar_addr; len = slave_ar_len; size = slave_ar_size; burst = slave_ar_burst;
    slave_ar_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    slave_ar_ready = 1'b0;
  endtask

  task automatic send_slave(input logic [SW-1:0] data, input logic [1:0] resp);
    int n = 0;
    slave_r_data = data; slave_r_resp = resp; slave_r_valid = 1'b1;
    while (!slave_r_ready && n < 50) begin @(negedge clk); n++; end
    if (!slave_r_ready) begin
      checks++; errors++;
      $display("FAIL slave_r_timeout got ready=%b required 1", slave_r_ready);
    end
    @(posedge clk); @(negedge clk);
    slave_r_valid = 1'b0;
  endtask

  task automatic recv_master(output logic [MW-1:0] data, output logic [1:0] resp,
                             output logic last);
    int n = 0;
    master_r_ready = 1'b1;
    while (!master_r_valid && n < 50) begin @(negedge clk); n++; end
    if (!master_r_valid) begin
      checks++; errors++;
      $display("FAIL master_r_timeout got valid=%b required 1", master_r_valid);
    end
    data = master_r_data; resp = master_r_resp; last = master_r_last;
    @(posedge clk); @(negedge clk);
    master_r_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (slave_ar_valid !== 1'b0 || master_r_valid !== 1'b0 || slave_r_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids got sar_v=%b mr_v=%b sr_r=%b required 0 0 0",
               slave_ar_valid, master_r_valid, slave_r_ready);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (master_ar_ready !== 1'b1 || master_r_data !== '0) begin
      errors++;
      $display("FAIL reset_idle got ar_ready=%b data=%h required 1 0", master_ar_ready, master_r_data);
    end
  endtask

  task automatic test_single_split();
    logic [7:0] a, l; logic [2:0] s; logic [1:0] b;
    logic [MW-1:0] d; logic [1:0] r; logic last;
    do_ar(8'h10, 8'd0, 3'd3, 2'b01);
    checks++;
    if (slave_ar_valid !== 1'b1) begin
      errors++; $display("FAIL t1_ar_latency got slave_ar_valid=%b required 1", slave_ar_valid);
    end
    wait_slave_ar(a, l, s, b);
    checks++;
    if (a !== 8'h10 || l !== 8'd1 || s !== 3'd2 || b !== 2'b01) begin
      errors++;
      $display("FAIL t1_slave_ar got addr=%h len=%0d size=%0d burst=%0d required 10 1 2 1", a, l, s, b);
    end
    send_slave(32'h11111111, 2'b00);
    send_slave(32'h22222222, 2'b00);
    checks++;
    if (master_r_valid !== 1'b1) begin
      errors++; $display("FAIL t1_r_latency got master_r_valid=%b required 1", master_r_valid);
    end
    recv_master(d, r, last);
    checks++;
    if (d !== 64'h2222222211111111 || last !== 1'b1 || r !== 2'b00) begin
      errors++;
      $display("FAIL t1_master_r got data=%h last=%b resp=%0d required 2222222211111111 1 0", d, last, r);
    end
    checks++;
    if (master_ar_ready !== 1'b1) begin
      errors++; $display("FAIL t1_idle_latency got ar_ready=%b required 1", master_ar_ready);
    end
  endtask

  task automatic test_multi_split();
    logic [7:0] a, l; logic [2:0] s; logic [1:0] b;
    logic [MW-1:0] d; logic [1:0] r; logic last;
    logic [SW-1:0] lo, hi;
    do_ar(8'h00, 8'd3, 3'd3, 2'b01);
    for (int k = 0; k < 4; k++) begin
      wait_slave_ar(a, l, s, b);
      checks++;
      if (a !== 8'(8 * k) || l !== 8'd1) begin
        errors++;
        $display("FAIL t2_slave_ar%0d got addr=%h len=%0d required %h 1", k, a, l, 8'(8 * k));
      end
      lo = 32'hA000_0000 + 32'(2 * k);
      hi = 32'hA000_0001 + 32'(2 * k);
      send_slave(lo, 2'b00);
      send_slave(hi, 2'b00);
      recv_master(d, r, last);
      checks++;
      if (d !== {hi, lo} || last !== (k == 3)) begin
        errors++;
        $display("FAIL t2_master_r%0d got data=%h last=%b required %h %b", k, d, last, {hi, lo}, (k == 3));
      end
    end
  endtask

  task automatic test_pass();
    logic [7:0] a, l; logic [2:0] s; logic [1:0] b;
    logic [MW-1:0] d; logic [1:0] r; logic last;
    do_ar(8'h04, 8'd1, 3'd2, 2'b01);
    wait_slave_ar(a, l, s, b);
    checks++;
    if (a !== 8'h04 || l !== 8'd1 || s !== 3'd2 || b !== 2'b01) begin
      errors++;
      $display("FAIL t3_slave_ar got addr=%h len=%0d size=%0d burst=%0d required 04 1 2 1", a, l, s, b);
    end
    send_slave(32'hAAAA5555, 2'b00);
    recv_master(d, r, last);
    checks++;
    if (d !== 64'hAAAA5555_00000000 || last !== 1'b0) begin
      errors++;
      $display("FAIL t3_beat0 got data=%h last=%b required aaaa555500000000 0", d, last);
    end
    send_slave(32'h12345678, 2'b00);
    recv_master(d, r, last);
    checks++;
    if (d !== 64'h00000000_12345678 || last !== 1'b1) begin
      errors++;
      $display("FAIL t3_beat1 got data=%h last=%b required 0000000012345678 1", d, last);
    end
  endtask

  task automatic test_resp_backpressure();
    logic [7:0] a, l; logic [2:0] s; logic [1:0] b;
    logic [MW-1:0] d; logic [1:0] r; logic last;
    do_ar(8'h30, 8'd0, 3'd3, 2'b01);
    wait_slave_ar(a, l, s, b);
    send_slave(32'hAAAAAAAA, 2'b00);
    send_slave(32'hBBBBBBBB, 2'b10);
    master_r_ready = 1'b0;
    slave_r_valid = 1'b1; slave_r_data = 32'hDEAD0000; slave_r_resp = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (slave_r_ready !== 1'b0 || master_r_valid !== 1'b1 || master_r_data !== 64'hBBBBBBBBAAAAAAAA) begin
        errors++;
        $display("FAIL t4_hold%0d got sr_ready=%b mr_valid=%b data=%h required 0 1 bbbbbbbbaaaaaaaa",
                 c, slave_r_ready, master_r_valid, master_r_data);
      end
    end
    slave_r_valid = 1'b0; slave_r_resp = 2'b00;
    recv_master(d, r, last);
    checks++;
    if (r !== 2'b10 || d !== 64'hBBBBBBBBAAAAAAAA || last !== 1'b1) begin
      errors++;
      $display("FAIL t4_resp got resp=%0d data=%h last=%b required 2 bbbbbbbbaaaaaaaa 1", r, d, last);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a, l; logic [2:0] s; logic [1:0] b;
    logic [MW-1:0] d; logic [1:0] r; logic last;
    do_ar(8'h40, 8'd0, 3'd3, 2'b01);
    wait_slave_ar(a, l, s, b);
    send_slave(32'hDEADBEEF, 2'b00);
    rstn = 1'b0;
    #1;
    checks++;
    if (slave_ar_valid !== 1'b0 || master_r_valid !== 1'b0 || slave_r_ready !== 1'b0) begin
      errors++;
      $display("FAIL t5_abort got sar_v=%b mr_v=%b sr_r=%b required 0 0 0",
               slave_ar_valid, master_r_valid, slave_r_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (master_ar_ready !== 1'b1) begin
      errors++; $display("FAIL t5_ready got ar_ready=%b required 1", master_ar_ready);
    end
    do_ar(8'h04, 8'd0, 3'd2, 2'b01);
    wait_slave_ar(a, l, s, b);
    checks++;
    if (a !== 8'h04 || l !== 8'd0 || s !== 3'd2) begin
      errors++;
      $display("FAIL t5_slave_ar got addr=%h len=%0d size=%0d required 04 0 2", a, l, s);
    end
    send_slave(32'hCAFEF00D, 2'b00);
    recv_master(d, r, last);
    checks++;
    if (d !== 64'hCAFEF00D_00000000 || last !== 1'b1 || r !== 2'b00) begin
      errors++;
      $display("FAIL t5_master_r got data=%h last=%b resp=%0d required cafef00d00000000 1 0", d, last, r);
    end
  endtask

  task automatic test_fixed_wrap();
    logic [7:0] a, l; logic [2:0] s; logic [1:0] b;
    logic [MW-1:0] d; logic [1:0] r; logic last;
    logic [7:0] wrap_exp [2];
    do_ar(8'h20, 8'd2, 3'd3, 2'b00);
    for (int k = 0; k < 3; k++) begin
      wait_slave_ar(a, l, s, b);
      checks++;
      if (a !== 8'h20 || l !== 8'd1 || s !== 3'd2 || b !== 2'b01) begin
        errors++;
        $display("FAIL t6_fixed_ar%0d got addr=%h len=%0d size=%0d burst=%0d required 20 1 2 1", k, a, l, s, b);
      end
      send_slave(32'h5000_0000 + 32'(k), 2'b00);
      send_slave(32'h6000_0000 + 32'(k), 2'b00);
      recv_master(d, r, last);
      checks++;
      if (d !== {32'h6000_0000 + 32'(k), 32'h5000_0000 + 32'(k)} || last !== (k == 2)) begin
        errors++;
        $display("FAIL t6_fixed_r%0d got data=%h last=%b", k, d, last);
      end
    end
    // WRAP of two 8-byte beats from 0x18 wraps to 0x10 inside a 16-byte window.
    wrap_exp[0] = 8'h18; wrap_exp[1] = 8'h10;
    do_ar(8'h18, 8'd1, 3'd3, 2'b10);
    for (int k = 0; k < 2; k++) begin
      wait_slave_ar(a, l, s, b);
      checks++;
      if (a !== wrap_exp[k]) begin
        errors++;
        $display("FAIL t7_wrap_ar%0d got addr=%h required %h", k, a, wrap_exp[k]);
      end
      send_slave(32'h7000_0000, 2'b00);
      send_slave(32'h8000_0000, 2'b00);
      recv_master(d, r, last);
    end
  endtask

  initial begin
    rstn = 1'b0;
    master_ar_id = '0; master_ar_addr = '0; master_ar_len = '0; master_ar_size = '0;
    master_ar_burst = '0; master_ar_lock = 1'b0; master_ar_cache = 4'h3;
    master_ar_prot = '0; master_ar_qos = '0; master_ar_region = '0; master_ar_user = '0;
    master_ar_valid = 1'b0; master_r_ready = 1'b0; slave_ar_ready = 1'b0;
    slave_r_id = '0; slave_r_data = '0; slave_r_resp = '0; slave_r_last = 1'b0;
    slave_r_user = '0; slave_r_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_split();
    test_multi_split();
    test_pass();
    test_resp_backpressure();
    test_reset_mid();
    test_fixed_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got time=%0t required completion", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
